quad_gate_tester: RTL and testbench

- Synthesizable self-test sequencer for quad 2-input gate parts in the 74xxx simulation library (7400/7402/7408/7432/7486 class).
- Drives the A/B inputs of the part under test through a fixed 8-step vector program.
- Samples the four Y outputs after a settle delay and compares each against a parameterized truth table.
- Sits opposite the device under test: it generates the stimulus and checks the response, replacing hand-written per-chip stimulus sequences.

---
 rtl/quad_gate_tester_pkg.sv | 21 ++
 rtl/quad_gate_tester_vector_gen.sv | 23 ++
 rtl/quad_gate_tester.sv | 118 +++++++++++
 tb/tb_quad_gate_tester.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/quad_gate_tester_pkg.sv
// Shared types and constants for the quad 2-input gate self-test sequencer.
package quad_gate_tester_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  localparam int unsigned NUM_STEPS = 8;
  localparam int unsigned NUM_GATES = 4;

  // Expected Y indexed by {a,b}.
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;

endpackage

// File: rtl/quad_gate_tester_vector_gen.sv
// Stimulus program: steps 0..3 give every gate v=step, steps 4..7 rotate v=(step+g) mod 4.
module gate_vector_gen
  import quad_gate_tester_pkg::*;
(
  input  logic [2:0] i_step,
  output logic [3:0] o_a,
  output logic [3:0] o_b
);

  logic [1:0] w_v;

  always_comb begin
    o_a = '0;
    o_b = '0;
    w_v = '0;
    for (int unsigned g = 0; g < NUM_GATES; g++) begin
      w_v    = i_step[1:0] + (i_step[2] ? 2'(g) : 2'd0);
      o_a[g] = w_v[1];
      o_b[g] = w_v[0];
    end
  end

endmodule

// File: rtl/quad_gate_tester.sv
// Drives an 8-step vector program into a quad 2-input gate part and checks
// each sampled Y against the TRUTH table, reporting per-gate failures.
module quad_gate_tester
  import quad_gate_tester_pkg::*;
#(
  parameter logic [3:0]  TRUTH  = TT_NOR,
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [3:0] a_out,
  output logic [3:0] b_out,
  input  logic [3:0] y_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [2:0] fail_step
);

  if (SETTLE < 1) begin : g_bad_settle
    $error("quad_gate_tester: SETTLE must be >= 1");
  end

  localparam int unsigned CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [2:0] LAST_STEP = 3'(NUM_STEPS - 1);

  state_t        r_state;
  state_t        w_next;
  logic [2:0]    r_step;
  logic [CW-1:0] r_settle;
  logic          r_pass;
  logic [3:0]    r_fail_mask;
  logic [2:0]    r_fail_step;

  logic [3:0]    w_vec_a;
  logic [3:0]    w_vec_b;
  logic [3:0]    w_exp;
  logic [3:0]    w_mism;
  logic [3:0]    w_mask_next;
  logic          w_drive;
  logic          w_settled;

  gate_vector_gen u_vec (
    .i_step (r_step),
    .o_a    (w_vec_a),
    .o_b    (w_vec_b)
  );

  assign w_drive   = (r_state == ST_DRIVE) || (r_state == ST_SAMPLE);
  assign w_settled = (r_settle == SETTLE_LAST);

  always_comb begin
    w_exp = '0;
    for (int unsigned g = 0; g < NUM_GATES; g++) begin
      w_exp[g] = TRUTH[{w_vec_a[g], w_vec_b[g]}];
    end
  end

  assign w_mism      = w_exp ^ y_in;
  assign w_mask_next = r_fail_mask | w_mism;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (start) w_next = ST_DRIVE;
      ST_DRIVE:  if (w_settled) w_next = ST_SAMPLE;
      ST_SAMPLE: w_next = (r_step == LAST_STEP) ? ST_DONE : ST_DRIVE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_step      <= '0;
      r_settle    <= '0;
      r_pass      <= 1'b0;
      r_fail_mask <= '0;
      r_fail_step <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_step      <= '0;
            r_settle    <= '0;
            r_pass      <= 1'b0;
            r_fail_mask <= '0;
            r_fail_step <= '0;
          end
        end
        ST_DRIVE: r_settle <= w_settled ? '0 : r_settle + CW'(1);
        ST_SAMPLE: begin
          r_fail_mask <= w_mask_next;
          if ((r_fail_mask == '0) && (w_mism != '0)) r_fail_step <= r_step;
          // pass is resolved on the last sample so it is already valid alongside done.
          if (r_step == LAST_STEP) r_pass <= (w_mask_next == '0);
          else                     r_step <= r_step + 3'd1;
        end
        ST_DONE: r_step <= '0;
        default: r_step <= '0;
      endcase
    end
  end

  assign a_out     = w_drive ? w_vec_a : '0;
  assign b_out     = w_drive ? w_vec_b : '0;
  assign busy      = w_drive;
  assign done      = (r_state == ST_DONE);
  assign pass      = r_pass;
  assign fail_mask = r_fail_mask;
  assign fail_step = r_fail_step;

endmodule

// File: tb/tb_quad_gate_tester.sv
// Directed bench: behavioural gate models with injectable faults opposite two tester instances.
module tb_quad_gate_tester;
  import quad_gate_tester_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start_n, start_a;
  logic [3:0] a_n, b_n, y_n, mask_n, a_a, b_a, y_a, mask_a;
  logic [2:0] fstep_n, fstep_a;
  logic busy_n, done_n, pass_n, busy_a, done_a, pass_a;

  int checks = 0;
  int errors = 0;
  int mode   = 0;
  int cyc    = 0;

  quad_gate_tester #(.TRUTH(TT_NOR), .SETTLE(2)) u_nor (
    .clk(clk), .reset(reset), .start(start_n), .a_out(a_n), .b_out(b_n), .y_in(y_n),
    .busy(busy_n), .done(done_n), .pass(pass_n), .fail_mask(mask_n), .fail_step(fstep_n)
  );

  quad_gate_tester #(.TRUTH(TT_AND), .SETTLE(1)) u_and (
    .clk(clk), .reset(reset), .start(start_a), .a_out(a_a), .b_out(b_a), .y_in(y_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .fail_mask(mask_a), .fail_step(fstep_a)
  );

  // 7402-style part with selectable faults; mode 5 corrupts Y outside SAMPLE cycles.
  always_comb begin
    y_n = ~(a_n | b_n);
    case (mode)
      1: y_n[2] = 1'b0;
      2: y_n[0] = ~b_n[0];
      3: y_n = ~y_n;
      4: y_n[1] = ~(a_n[1] ^ b_n[1]);
      5: if (cyc % 3 != 0) y_n = ~y_n;
      default: ;
    endcase
  end

  assign y_a = a_a & b_a;

  typedef struct {
    int         mode;
    logic       exp_pass;
    logic [3:0] exp_mask;
    logic [2:0] exp_step;
  } run_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
  } trace_t;

  run_t   runs[6];
  trace_t trace[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // sel=0: NOR instance, sel=1: AND instance (with a/b trace check at each SAMPLE cycle)
  task automatic run(input bit sel, output int done_at, output int busy_cnt);
    @(negedge clk);
    if (sel) start_a = 1'b1; else start_n = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_n = 1'b0;
    done_at  = 0;
    busy_cnt = 0;
    for (int k = 1; k <= 40 && done_at == 0; k++) begin
      cyc = k;
      @(negedge clk);
      if (sel ? busy_a : busy_n) busy_cnt++;
      if (sel ? done_a : done_n) done_at = k;
      if (sel && (k % 2 == 0) && (k <= 16)) begin
        chk($sformatf("trace_a step%0d", k / 2 - 1), a_a, trace[k/2-1].a);
        chk($sformatf("trace_b step%0d", k / 2 - 1), b_a, trace[k/2-1].b);
      end
      @(posedge clk); #1;
    end
  endtask

  int done_at, busy_cnt, dones, d1, d2;
  logic p1, p2;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    runs[0] = '{0, 1'b1, 4'b0000, 3'd0};
    runs[1] = '{1, 1'b0, 4'b0100, 3'd0};
    runs[2] = '{2, 1'b0, 4'b0001, 3'd2};
    runs[3] = '{3, 1'b0, 4'b1111, 3'd0};
    runs[4] = '{4, 1'b0, 4'b0010, 3'd3};
    runs[5] = '{5, 1'b1, 4'b0000, 3'd0};

    trace[0] = '{4'b0000, 4'b0000};
    trace[1] = '{4'b0000, 4'b1111};
    trace[2] = '{4'b1111, 4'b0000};
    trace[3] = '{4'b1111, 4'b1111};
    trace[4] = '{4'b1100, 4'b1010};
    trace[5] = '{4'b0110, 4'b0101};
    trace[6] = '{4'b0011, 4'b1010};
    trace[7] = '{4'b1001, 4'b0101};

    reset = 1'b1; start_n = 1'b0; start_a = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset busy",  {busy_n, busy_a}, 2'b00);
    chk("reset done",  {done_n, done_a}, 2'b00);
    chk("reset pass",  {pass_n, pass_a}, 2'b00);
    chk("reset mask",  {mask_n, mask_a}, 8'h00);
    chk("reset step",  {fstep_n, fstep_a}, 6'd0);
    chk("reset ab",    {a_n, b_n, a_a, b_a}, 16'h0000);

    for (int i = 0; i < 6; i++) begin
      mode = runs[i].mode;
      run(1'b0, done_at, busy_cnt);
      chk($sformatf("run%0d done_at", i), done_at, 25);
      chk($sformatf("run%0d busy_cnt", i), busy_cnt, 24);
      @(negedge clk);
      chk($sformatf("run%0d pass", i), pass_n, runs[i].exp_pass);
      chk($sformatf("run%0d mask", i), mask_n, runs[i].exp_mask);
      if (runs[i].exp_mask != 4'b0000)
        chk($sformatf("run%0d fail_step", i), fstep_n, runs[i].exp_step);
      chk($sformatf("run%0d idle ab", i), {a_n, b_n, busy_n}, 9'd0);
    end
    mode = 0;

    run(1'b1, done_at, busy_cnt);
    chk("and done_at", done_at, 17);
    chk("and busy_cnt", busy_cnt, 16);
    @(negedge clk);
    chk("and pass", pass_a, 1'b1);
    chk("and mask", mask_a, 4'b0000);

    // start re-asserted mid-run is ignored
    @(negedge clk); start_n = 1'b1;
    @(posedge clk); #1; start_n = 1'b0;
    dones = 0; done_at = 0;
    for (int k = 1; k <= 35; k++) begin
      start_n = (k == 5);
      @(negedge clk);
      if (done_n) begin dones++; if (done_at == 0) done_at = k; end
      @(posedge clk); #1;
    end
    start_n = 1'b0;
    chk("restart dones", dones, 1);
    chk("restart done_at", done_at, 25);

    // reset mid-run with a failure already latched
    mode = 1;
    @(negedge clk); start_n = 1'b1;
    @(posedge clk); #1; start_n = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("pre-abort mask", mask_n, 4'b0100);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort busy", busy_n, 1'b0);
    chk("abort ab", {a_n, b_n}, 8'h00);
    chk("abort pass", pass_n, 1'b0);
    chk("abort mask", mask_n, 4'b0000);
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done_n) dones++;
    end
    chk("abort no done", dones, 0);
    mode = 0;

    // start held high: back-to-back runs
    @(negedge clk); start_n = 1'b1;
    @(posedge clk); #1;
    dones = 0; d1 = 0; d2 = 0; p1 = 1'b0; p2 = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done_n) begin
        dones++;
        if (dones == 1) begin d1 = k; p1 = pass_n; end
        if (dones == 2) begin d2 = k; p2 = pass_n; end
      end
      @(posedge clk); #1;
    end
    start_n = 1'b0;
    chk("held dones", dones, 2);
    chk("held first done", d1, 25);
    chk("held spacing", d2 - d1, 26);
    chk("held pass1", p1, 1'b1);
    chk("held pass2", p2, 1'b1);
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
